// File: rtl/serial_alu_sequencer_if.sv
// Request/result handshake bundle for the bit-serial ALU sequencer.
// The slave modport is the sequencer. The master modport is the datapath that issues operations.
interface serial_alu_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             err;

  modport slave (
    input  in_valid, ctl, a, b, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero, err
  );

  modport master (
    output in_valid, ctl, a, b, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero, err
  );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU: runs one 1-bit slice for WIDTH cycles, LSB first.
// Supported funct codes are ADD/SUB/AND/OR/SLT. Any other code executes as ADD and sets err.
module serial_alu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_alu_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_SLT = 6'd42;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_reg, b_reg, result_sr;
  logic [5:0]       ctl_reg, s_ctl;
  logic             invb, carry, legal, last;
  logic [CW-1:0]    cnt;
  logic             s_a, s_b, s_sum, s_cout, v;
  logic [WIDTH-1:0] full, fin_res, res_q;
  logic             fin_cout, fin_ovf;
  logic             cout_q, ovf_q, zero_q, err_q;

  // One-bit slice. Its carry chain is evaluated for every op, but AND and OR discard the final carry.
  always_comb begin
    legal = ctl_reg inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    s_ctl = legal ? ctl_reg : F_ADD;
    s_a   = a_reg[cnt];
    s_b   = b_reg[cnt] ^ invb;
    case (s_ctl)
      F_AND:   s_sum = s_a & s_b;
      F_OR:    s_sum = s_a | s_b;
      default: s_sum = s_a ^ s_b ^ carry;
    endcase
    s_cout = (s_a & s_b) | (s_a & carry) | (s_b & carry);
  end

  // Result/flag formation at the MSB bit. Here, carry is the MSB carry-in.
  always_comb begin
    last     = (state_q == RUN) && (cnt == CW'(WIDTH - 1));
    full     = result_sr | (WIDTH'(s_sum) << (WIDTH - 1));
    v        = carry ^ s_cout;
    fin_res  = full;
    fin_cout = s_cout;
    fin_ovf  = 1'b0;
    case (s_ctl)
      F_ADD, F_SUB: fin_ovf  = v;
      F_AND, F_OR:  fin_cout = 1'b0;
      F_SLT:        fin_res  = WIDTH'(s_sum ^ v);
      default:      fin_ovf  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      ctl_reg   <= '0;
      invb      <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      result_sr <= '0;
      res_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            ctl_reg   <= bus.ctl;
            invb      <= (bus.ctl == F_SUB) || (bus.ctl == F_SLT);
            carry     <= (bus.ctl == F_SUB) || (bus.ctl == F_SLT);
            cnt       <= '0;
            result_sr <= '0;
          end
        end
        RUN: begin
          result_sr[cnt] <= s_sum;
          carry          <= s_cout;
          if (last) begin
            cnt    <= '0;
            res_q  <= fin_res;
            cout_q <= fin_cout;
            ovf_q  <= fin_ovf;
            zero_q <= (fin_res == '0);
            err_q  <= ~legal;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboard bench for serial_alu_sequencer.
// Expected results come from an arithmetic reference model. A separate monitor checks every presented result.
module tb_serial_alu_sequencer;
  localparam int unsigned W = 32;
  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_SLT = 6'd42;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;
  time  t_acc = 0;
  logic prev_ov = 1'b0;
  exp_t sb[$];

  serial_alu_sequencer_if #(.WIDTH(W)) bus ();

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] c);
    return c == F_ADD || c == F_SUB || c == F_AND || c == F_OR || c == F_SLT;
  endfunction

  // Reference model: plain signed/unsigned arithmetic on whole operands.
  function automatic exp_t model(input logic [5:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, sr, maxv, minv;
    longint unsigned us;
    e    = '0;
    sx   = $signed(x);
    sy   = $signed(y);
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -(longint'(1) <<< (W - 1));
    if (c == F_SUB) begin
      e.res  = x - y;
      e.cout = (x >= y);
      sr     = sx - sy;
      e.ovf  = (sr > maxv) || (sr < minv);
    end else if (c == F_SLT) begin
      e.res  = (sx < sy) ? W'(1) : '0;
      e.cout = (x >= y);
    end else if (c == F_AND) begin
      e.res = x & y;
    end else if (c == F_OR) begin
      e.res = x | y;
    end else begin
      us     = longint'(x) + longint'(y);
      e.res  = x + y;
      e.cout = us[W];
      sr     = sx + sy;
      e.ovf  = (sr > maxv) || (sr < minv);
      e.err  = !is_legal(c);
    end
    e.zero = (e.res == '0);
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares presented outputs with the scoreboard head every cycle and pops on handshake.
  always @(negedge clk) begin
    longint lat;
    exp_t   e;
    if (bus.out_valid) begin
      chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
      if (!prev_ov) begin
        lat = longint'($time - 5 - t_acc) / 10 + 1;
        chk("latency_edges", 64'(lat), 64'(W + 1));
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", bus.result);
      end else begin
        e = sb[0];
        chk("result", 64'(bus.result), 64'(e.res));
        chk("cout",   64'(bus.cout),   64'(e.cout));
        chk("ovf",    64'(bus.ovf),    64'(e.ovf));
        chk("zero",   64'(bus.zero),   64'(e.zero));
        chk("err",    64'(bus.err),    64'(e.err));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic issue(input logic [5:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    @(negedge clk);
    bus.ctl = c;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_in_ready required=in_ready");
      bus.in_valid = 1'b0;
    end else begin
      sb.push_back(model(c, x, y));
      @(posedge clk);
      t_acc = $time;
      #1;
      bus.in_valid = 1'b0;
      bus.ctl = 6'($urandom);
      bus.a = $urandom;
      bus.b = $urandom;
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] c;
    logic [5:0] codes [5];
    codes[0] = F_ADD; codes[1] = F_SUB; codes[2] = F_AND; codes[3] = F_OR; codes[4] = F_SLT;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.ctl = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_result",    64'(bus.result),    64'd0);
    chk("rst_flags",     64'({bus.cout, bus.ovf, bus.zero, bus.err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    issue(F_ADD, 32'hFFFF_FFFF, 32'h1);        wait_empty();
    issue(F_SUB, 32'd5, 32'd7);                wait_empty();
    issue(F_ADD, 32'h7FFF_FFFF, 32'h1);        wait_empty();
    issue(F_SLT, 32'h8000_0000, 32'h1);        wait_empty();
    issue(F_SLT, 32'd7, 32'd3);                wait_empty();
    issue(F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00); wait_empty();
    issue(F_OR,  32'hF0F0_F0F0, 32'hFF00_FF00); wait_empty();
    issue(6'd0,  32'd2, 32'd3);                wait_empty();

    // Backpressure: the result is held while out_ready is low, and a request arriving then is ignored.
    rdy_mode = 1;
    issue(F_SUB, $urandom, $urandom);
    for (int i = 0; i < 200 && !bus.out_valid; i++) @(negedge clk);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.ctl = F_ADD;
        bus.a = $urandom;
        bus.b = $urandom;
      end
      if (i == 5) bus.in_valid = 1'b0;
    end
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs_in_ready",  64'(bus.in_ready),  64'd1);
    chk("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
    wait_empty();

    // Reset while bit 10 is in progress: the pending result is discarded.
    issue(F_ADD, $urandom, $urandom);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mid_rst_result",    64'(bus.result),    64'd0);
    chk("mid_rst_flags",     64'({bus.cout, bus.ovf, bus.zero, bus.err}), 64'd0);
    issue(F_ADD, 32'd1, 32'd1);
    wait_empty();

    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        c = 6'($urandom_range(0, 63));
        while (is_legal(c)) c = 6'($urandom_range(0, 63));
      end else begin
        c = codes[$urandom_range(0, 4)];
      end
      issue(c, pick_operand(), pick_operand());
    end
    wait_empty();
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_alu_sequencer.md
# serial_alu_sequencer

Bit-serial ALU engine that runs one 1-bit ALU slice (AND/OR/ADD/SUB/SLT, MIPS funct encoding) for WIDTH clock cycles, LSB first, to produce a full-width result. It is the initiator side of the slice interface. Each cycle it drives ctl, a, b, invb and cin into the slice, then captures sum and cout. Upstream, a datapath hands it operations over a valid/ready handshake; downstream, the same handshake returns the result and flags.

## Interface
- WIDTH, 32, operand/result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- ctl  input  6  funct code: 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- cout  output  1  final carry out of the MSB slice; 0 for AND/OR.
- ovf  output  1  signed overflow; set only for ADD/SUB, 0 otherwise.
- zero  output  1  result == 0.
- err  output  1  ctl was not one of the five legal codes.

## Operation
- States are IDLE, RUN and DONE.
- IDLE
  - in_ready = 1.
  - On in_valid, latch a, b and ctl into internal registers; bit counter cnt = 0.
  - invb = (ctl==34 || ctl==42).
  - carry register = invb.
  - Go to RUN.
- RUN
  - Slice inputs are a_reg[cnt], b_reg[cnt], invb and carry.
  - Slice ctl is the latched code; an illegal code is driven as 32.
  - On each edge, shift the slice sum into result_sr[cnt], load carry with the slice cout, and increment cnt.
  - When cnt == WIDTH-1, also capture the MSB carry-in (carry_msb) and the slice sum (sum_msb), then go to DONE.
- Leaving RUN computes:
  - ovf = carry_msb ^ final carry, only for ADD/SUB.
  - SLT: result = {WIDTH-1 zeros, sum_msb ^ (carry_msb ^ final carry)}; cout = final carry; ovf = 0.
  - AND/OR: cout = 0.
  - Illegal ctl: executes as ADD, err = 1.
  - zero is computed from the final result value.
- DONE
  - out_valid = 1; result and all flags are held stable.
  - On out_ready, go to IDLE and clear out_valid.
  - No new request is accepted while in DONE.
- in_ready = (state==IDLE) & ~rst, so it is 0 in RUN, in DONE and during reset.
- Inputs a, b and ctl are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset state:
  - state = IDLE, cnt = 0, carry = 0.
  - out_valid = 0, result = 0, cout = 0, ovf = 0, zero = 0, err = 0.
- Accept occurs at the edge where in_valid & in_ready. RUN then spans exactly WIDTH cycles.
- Latency: out_valid rises WIDTH+1 edges after the accept edge.
- Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH bits, handoff), with out_ready held high.
- Result handshake completes at the edge where out_valid & out_ready. in_ready is 1 in the following cycle.
- Backpressure: out_ready may stay low indefinitely; outputs must not change meanwhile.
- Reset mid-RUN or mid-DONE: at that edge, return to the reset state. The partial or pending result is discarded and out_valid is never pulsed.
- rst has priority over every other event at the same edge.
- in_valid asserted outside IDLE is ignored. The requester must hold in_valid until it sees in_ready.
- The counter is $clog2(WIDTH) bits wide. It never wraps inside RUN and is cleared on entry to RUN.

## Test plan
- ADD a=0xFFFFFFFF, b=1 -> result 0x00000000, cout=1, zero=1, ovf=0, err=0; out_valid exactly 33 edges after accept.
- SUB a=5, b=7 -> result 0xFFFFFFFE, cout=0, ovf=0. Also ADD a=0x7FFFFFFF, b=1 -> 0x80000000, ovf=1.
- SLT a=0x80000000, b=1 -> result 1 (overflow-corrected). SLT a=7, b=3 -> result 0, zero=1.
- AND a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000. OR of the same operands -> 0xFFF0FFF0; cout=0 for both. ctl=0 with a=2, b=3 -> result 5, err=1.
- Backpressure: out_ready low for 10 cycles after out_valid -> result and flags stable, in_ready=0, and an in_valid pulse in that window is not accepted.
- Reset at RUN bit 10 -> next cycle out_valid=0, in_ready=1, all outputs 0. A new ADD 1+1 then returns 2 with normal latency.
